// File: rtl/fsm_seq_checker_if.sv
// Link-side bundle between the serial sequence source and fsm_seq_checker.
// master drives the sample stream and clear; slave is the checker.
interface fsm_seq_checker_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             y_in;
  logic             clr;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       phase;
  logic             period_done;

  modport master (
    output en, y_in, clr,
    input  locked, err, err_cnt, phase, period_done
  );

  modport slave (
    input  en, y_in, clr,
    output locked, err, err_cnt, phase, period_done
  );
endinterface

// File: rtl/fsm_seq_checker.sv
// Phase-locking checker for the 1,1,1,0 cyclic stream: hunts for the zero,
// verifies whole periods before locking, then flywheels and counts errors.
module fsm_seq_checker #(
  parameter int LOCK_PERIODS   = 2,
  parameter int UNLOCK_PERIODS = 2,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  fsm_seq_checker_if.slave bus
);

  localparam int GW = $clog2(LOCK_PERIODS + 1);
  localparam int BW = $clog2(UNLOCK_PERIODS + 1);
  localparam logic [GW-1:0] GOOD_LIM = GW'(LOCK_PERIODS);
  localparam logic [BW-1:0] BAD_LIM  = BW'(UNLOCK_PERIODS);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       phase, phase_n;
  logic [GW-1:0]    good_cnt, good_n, good_inc;
  logic [BW-1:0]    bad_cnt, bad_n, bad_inc;
  logic             period_bad, period_bad_n;
  logic             err_r, err_n;
  logic             pd_r, pd_n;
  logic [CNT_W-1:0] err_cnt, err_cnt_n;

  logic [1:0]       next_phase;
  logic             at_zero;
  logic             match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The generator counts down, so the expected bit is known from the next phase.
  assign next_phase = phase - 2'd1;
  assign at_zero    = (next_phase == 2'b00);
  assign match      = (bus.y_in == !at_zero);
  assign good_inc   = good_cnt + 1'b1;
  assign bad_inc    = bad_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      phase      <= 2'b11;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      period_bad <= 1'b0;
      err_r      <= 1'b0;
      pd_r       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      good_cnt   <= good_n;
      bad_cnt    <= bad_n;
      period_bad <= period_bad_n;
      err_r      <= err_n;
      pd_r       <= pd_n;
      err_cnt    <= err_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    good_n       = good_cnt;
    bad_n        = bad_cnt;
    period_bad_n = period_bad;
    err_n        = 1'b0;
    pd_n         = 1'b0;
    err_cnt_n    = err_cnt;

    if (bus.en) begin
      unique case (state)
        HUNT: begin
          if (!bus.y_in) begin
            state_n = TRACK;
            phase_n = 2'b00;
            good_n  = '0;
          end else begin
            phase_n = 2'b11;
          end
        end

        TRACK: begin
          if (match) begin
            phase_n = next_phase;
            if (at_zero) begin
              pd_n   = 1'b1;
              good_n = good_inc;
              if (good_inc == GOOD_LIM) begin
                state_n      = LOCKED;
                bad_n        = '0;
                period_bad_n = 1'b0;
              end
            end
          end else if (!bus.y_in) begin
            // A zero where a one was due is a fresh candidate anchor.
            phase_n = 2'b00;
            good_n  = '0;
          end else begin
            state_n = HUNT;
            phase_n = 2'b11;
            good_n  = '0;
          end
        end

        LOCKED: begin
          phase_n = next_phase;
          if (!match) begin
            err_n        = 1'b1;
            err_cnt_n    = sat_inc(err_cnt);
            period_bad_n = 1'b1;
          end
          if (at_zero) begin
            pd_n         = 1'b1;
            period_bad_n = 1'b0;
            if (period_bad || !match) begin
              bad_n = bad_inc;
              if (bad_inc == BAD_LIM) begin
                state_n = HUNT;
                phase_n = 2'b11;
                good_n  = '0;
              end
            end else begin
              bad_n = '0;
            end
          end
        end

        default: begin
          state_n = HUNT;
          phase_n = 2'b11;
          good_n  = '0;
        end
      endcase
    end

    if (bus.clr) err_cnt_n = '0;
  end

  assign bus.locked      = (state == LOCKED);
  assign bus.err         = err_r;
  assign bus.err_cnt     = err_cnt;
  assign bus.phase       = phase;
  assign bus.period_done = pd_r;

endmodule

// File: tb/tb_fsm_seq_checker.sv
// Directed bench for fsm_seq_checker: acquisition, error flagging, unlock,
// sparse strobes, counter saturation with clear, and asynchronous reset.
module tb_fsm_seq_checker;

  localparam int CNT_W = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  fsm_seq_checker_if #(.CNT_W(CNT_W)) bus ();

  fsm_seq_checker #(
    .LOCK_PERIODS  (2),
    .UNLOCK_PERIODS(2),
    .CNT_W         (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int ACQ_Y  [11] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0};
  localparam int ACQ_PH [11] = '{3, 3, 0, 3, 2, 1, 0, 3, 2, 1, 0};
  localparam int ACQ_PD [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
  localparam int ACQ_LK [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  task automatic step(input logic e, input logic y, input logic c);
    bus.en   = e;
    bus.y_in = y;
    bus.clr  = c;
    @(posedge clk);
    #1;
  endtask

  // One generator period (phases 11,10,01,00 -> bits 1,1,1,0), flip[k] inverts sample k.
  task automatic send_period(input logic [3:0] flip);
    for (int k = 0; k < 4; k++) step(1'b1, (k != 3) ^ flip[k], 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
    n_cmp++; if (bus.phase !== 2'b11) begin n_bad++; $display("FAIL reset_phase: got %b want 11", bus.phase); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.period_done !== 1'b0) begin n_bad++; $display("FAIL reset_pd: got %b want 0", bus.period_done); end
    n_cmp++; if (bus.err_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_errcnt: got %0d want 0", bus.err_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_acquire;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'(ACQ_Y[i]), 1'b0);
      n_cmp++; if (bus.phase !== 2'(ACQ_PH[i])) begin n_bad++; $display("FAIL acq_phase[%0d]: got %b want %b", i, bus.phase, 2'(ACQ_PH[i])); end
      n_cmp++; if (bus.period_done !== 1'(ACQ_PD[i])) begin n_bad++; $display("FAIL acq_pd[%0d]: got %b want %0d", i, bus.period_done, ACQ_PD[i]); end
      n_cmp++; if (bus.locked !== 1'(ACQ_LK[i])) begin n_bad++; $display("FAIL acq_locked[%0d]: got %b want %0d", i, bus.locked, ACQ_LK[i]); end
      n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL acq_err[%0d]: got %b want 0", i, bus.err); end
    end
    n_cmp++; if (bus.err_cnt !== 2'd0) begin n_bad++; $display("FAIL acq_errcnt: got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_single_error;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL single_err_pulse: got %b want 1", bus.err); end
    n_cmp++; if (bus.err_cnt !== 2'd1) begin n_bad++; $display("FAIL single_errcnt: got %0d want 1", bus.err_cnt); end
    n_cmp++; if (bus.phase !== 2'b10) begin n_bad++; $display("FAIL single_phase: got %b want 10", bus.phase); end
    step(1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL single_err_clear: got %b want 0", bus.err); end
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.period_done !== 1'b1) begin n_bad++; $display("FAIL single_pd: got %b want 1", bus.period_done); end
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL single_locked: got %b want 1", bus.locked); end
    send_period(4'b0000);
    send_period(4'b0010);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL single_badcnt_reset: got locked=%b want 1", bus.locked); end
    n_cmp++; if (bus.err_cnt !== 2'd2) begin n_bad++; $display("FAIL single_errcnt2: got %0d want 2", bus.err_cnt); end
    send_period(4'b0000);
    step(1'b1, 1'b1, 1'b1);
    n_cmp++; if (bus.err_cnt !== 2'd0) begin n_bad++; $display("FAIL single_clr: got %0d want 0", bus.err_cnt); end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.phase !== 2'b00 || bus.locked !== 1'b1) begin n_bad++; $display("FAIL single_end: got phase=%b locked=%b want 00/1", bus.phase, bus.locked); end
  endtask

  task automatic test_unlock;
    send_period(4'b0010);
    n_cmp++; if (bus.locked !== 1'b1 || bus.err_cnt !== 2'd1) begin n_bad++; $display("FAIL unlock_first: got locked=%b cnt=%0d want 1/1", bus.locked, bus.err_cnt); end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL unlock_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.period_done !== 1'b1) begin n_bad++; $display("FAIL unlock_pd: got %b want 1", bus.period_done); end
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL unlock_locked: got %b want 0", bus.locked); end
    n_cmp++; if (bus.phase !== 2'b11) begin n_bad++; $display("FAIL unlock_phase: got %b want 11", bus.phase); end
    n_cmp++; if (bus.err_cnt !== 2'd2) begin n_bad++; $display("FAIL unlock_errcnt: got %0d want 2", bus.err_cnt); end
    // Anchor, then an early zero must re-anchor without counting errors.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.phase !== 2'b00 || bus.period_done !== 1'b0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL track_reanchor: got phase=%b pd=%b err=%b want 00/0/0", bus.phase, bus.period_done, bus.err); end
    n_cmp++; if (bus.err_cnt !== 2'd2) begin n_bad++; $display("FAIL track_errcnt: got %0d want 2", bus.err_cnt); end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.phase !== 2'b11 || bus.period_done !== 1'b0) begin n_bad++; $display("FAIL track_tohunt: got phase=%b pd=%b want 11/0", bus.phase, bus.period_done); end
    step(1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.phase !== 2'b11) begin n_bad++; $display("FAIL hunt_hold: got %b want 11", bus.phase); end
    send_period(4'b0000);
    n_cmp++; if (bus.phase !== 2'b00 || bus.period_done !== 1'b0 || bus.locked !== 1'b0) begin n_bad++; $display("FAIL relock_anchor: got phase=%b pd=%b locked=%b want 00/0/0", bus.phase, bus.period_done, bus.locked); end
    send_period(4'b0000);
    n_cmp++; if (bus.period_done !== 1'b1 || bus.locked !== 1'b0) begin n_bad++; $display("FAIL relock_first: got pd=%b locked=%b want 1/0", bus.period_done, bus.locked); end
    send_period(4'b0000);
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL relock_second: got %b want 1", bus.locked); end
  endtask

  task automatic test_saturate;
    step(1'b1, 1'b1, 1'b1);
    n_cmp++; if (bus.err_cnt !== 2'd0) begin n_bad++; $display("FAIL sat_clr0: got %0d want 0", bus.err_cnt); end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, (k == 3), 1'b0);
      n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL sat_err[%0d]: got %b want 1", k, bus.err); end
      n_cmp++; if (bus.err_cnt !== 2'((k < 2) ? k + 1 : 3)) begin n_bad++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, bus.err_cnt, (k < 2) ? k + 1 : 3); end
    end
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.err_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_hold: got %0d want 3", bus.err_cnt); end
    step(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL sat_clr_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.err_cnt !== 2'd0) begin n_bad++; $display("FAIL sat_clr_cnt: got %0d want 0", bus.err_cnt); end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.locked !== 1'b0 || bus.phase !== 2'b11) begin n_bad++; $display("FAIL sat_unlock: got locked=%b phase=%b want 0/11", bus.locked, bus.phase); end
  endtask

  task automatic test_sparse_en;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'(ACQ_Y[i]), 1'b0);
      n_cmp++; if (bus.phase !== 2'(ACQ_PH[i]) || bus.period_done !== 1'(ACQ_PD[i]) || bus.locked !== 1'(ACQ_LK[i])) begin
        n_bad++; $display("FAIL sparse_on[%0d]: got phase=%b pd=%b locked=%b want %b/%0d/%0d", i, bus.phase, bus.period_done, bus.locked, 2'(ACQ_PH[i]), ACQ_PD[i], ACQ_LK[i]);
      end
      step(1'b0, !1'(ACQ_Y[i]), 1'b0);
      n_cmp++; if (bus.phase !== 2'(ACQ_PH[i]) || bus.period_done !== 1'b0 || bus.err !== 1'b0 || bus.locked !== 1'(ACQ_LK[i])) begin
        n_bad++; $display("FAIL sparse_off[%0d]: got phase=%b pd=%b err=%b locked=%b want %b/0/0/%0d", i, bus.phase, bus.period_done, bus.err, bus.locked, 2'(ACQ_PH[i]), ACQ_LK[i]);
      end
    end
    n_cmp++; if (bus.err_cnt !== 2'd0) begin n_bad++; $display("FAIL sparse_errcnt: got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_async_reset;
    step(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.err_cnt !== 2'd1 || bus.locked !== 1'b1) begin n_bad++; $display("FAIL arst_pre: got cnt=%0d locked=%b want 1/1", bus.err_cnt, bus.locked); end
    bus.en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL arst_locked: got %b want 0", bus.locked); end
    n_cmp++; if (bus.phase !== 2'b11) begin n_bad++; $display("FAIL arst_phase: got %b want 11", bus.phase); end
    n_cmp++; if (bus.err_cnt !== 2'd0) begin n_bad++; $display("FAIL arst_errcnt: got %0d want 0", bus.err_cnt); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL arst_err: got %b want 0", bus.err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    bus.en   = 1'b0;
    bus.y_in = 1'b1;
    bus.clr  = 1'b0;
    #2;
    test_reset();
    test_acquire();
    test_single_error();
    test_unlock();
    test_saturate();
    test_sparse_en();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_seq_checker.md
Name: fsm_seq_checker

Overview:
- Receive-side checker for the 2-bit cyclic sequence generator's serial output `y`.
- The generator resets to state 11 and steps 11→10→01→00→11. `y` is 0 only in state 00, so the stream is 1,1,1,0 repeating with period 4.
- This block hunts for the pattern, locks onto its phase and flywheels the expected generator state.
- It flags and counts mismatches, and drops lock after persistent corruption.
- It sits at the far end of the link, on the same clock domain as the generator.

Parameters:
- LOCK_PERIODS, 2: consecutive good 4-sample periods needed to declare lock (≥1).
- UNLOCK_PERIODS, 2: consecutive bad periods while locked that force a return to hunt (≥1).
- CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  sample strobe; `y_in` is consumed only on cycles with en=1.
- y_in  in  1  serial stream from the generator.
- clr  in  1  synchronous clear of err_cnt.
- locked  out  1  high while in LOCKED.
- err  out  1  one-cycle pulse on a mismatch while locked.
- err_cnt  out  CNT_W  saturating count of mismatches seen while locked.
- phase  out  2  recovered generator state for the most recently consumed sample.
- period_done  out  1  one-cycle pulse when a sample with phase 00 is consumed in TRACK or LOCKED.

Behaviour:
- Reset (asynchronous, active-high):
  - state=HUNT, phase=2'b11, locked=0, err=0, period_done=0, err_cnt=0.
  - Internal good_cnt=0, bad_cnt=0, period_bad=0.
  - Reset mid-operation abandons lock immediately.
- Output timing:
  - All outputs are registered and update on the clk edge that consumes the sample, i.e. visible the cycle after en=1.
  - en=0: all state held; err and period_done are 0.
- Expected bit: exp = (next_phase != 2'b00), where next_phase = phase - 1 (mod 4, so 00 wraps to 11).
- HUNT:
  - On en with y_in=0: phase←00, go to TRACK, good_cnt←0.
  - On en with y_in=1: stay in HUNT, phase stays 11.
  - period_done is not asserted on this anchoring sample.
- TRACK:
  - Each en advances phase←next_phase.
  - Mismatch with y_in=0 (unexpected 0): re-anchor phase←00, good_cnt←0, stay in TRACK, no period_done.
  - Mismatch with y_in=1: go to HUNT, phase←11, good_cnt←0.
  - Match on a phase-00 sample: period_done=1 and good_cnt++. When good_cnt reaches LOCK_PERIODS: go to LOCKED, locked=1, bad_cnt←0.
- LOCKED:
  - Flywheel: phase always advances; no re-anchoring on mismatch.
  - Each mismatch: err=1, err_cnt saturating +1 (holds at all-ones), period_bad←1.
  - On a phase-00 sample: period_done=1.
    - If the period was bad (including a mismatch on this sample): bad_cnt++. When bad_cnt reaches UNLOCK_PERIODS: go to HUNT, locked=0, phase←11, good_cnt←0.
    - If the period was good: bad_cnt←0.
    - period_bad is then cleared.
- err_cnt changes only in LOCKED.
- clr and an increment in the same cycle: clr wins, err_cnt=0, but err still pulses.
- Counters good_cnt and bad_cnt are sized to hold their limits and never wrap.

Test Plan:
- Reset then clean stream with en=1 every cycle, samples 1,1,0,1,1,1,0,1,1,1,0 (LOCK_PERIODS=2) -> TRACK anchors on sample 3; period_done after samples 7 and 11; locked=1 the cycle after sample 11; phase tracks 00,11,10,01,00; err_cnt=0.
- Locked, one inverted bit (a 0 where phase 10 expects 1) -> err pulses one cycle, err_cnt=1, locked stays 1; the next clean period resets bad_cnt.
- Locked, two consecutive periods each with one flipped bit (UNLOCK_PERIODS=2) -> err_cnt=2; locked falls the cycle after the second period's phase-00 sample; phase=11; the block re-hunts and relocks after 2 clean periods.
- en toggled 1,0,1,0 over a clean stream -> results identical to the dense-en case except for timing; no outputs change on en=0 cycles.
- CNT_W=2 with 5 errors while locked, then clr asserted in the same cycle as an error -> err_cnt saturates at 3; the clr cycle gives err=1 and err_cnt=0.
- Async rst asserted mid-LOCKED, between clock edges -> locked=0, phase=11, err_cnt=0 immediately, without waiting for a clock edge.
